pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the 3-stage core (IF, ID, EX). Merges branch/jump redirects and hold requests from the execute stage with data-bus wait states and external interrupts. Drives PC redirect, per-register hold and flush strobes. Sits beside `ex` and owns all stall and flush decisions.

## Interface
Parameters:
- `IRQ_VEC`, 32'h0000_0100: PC loaded on interrupt entry.
- `BUS_TIMEOUT`, 16: maximum BUS_WAIT cycles before abort; legal range 2..65535.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ex_valid_i`  in  1  EX holds a real (non-bubble) instruction.
- `ex_ins_addr_i`  in  32  address of the instruction in EX.
- `jump_en_i`  in  1  redirect request from EX.
- `jump_addr_i`  in  32  redirect target from EX.
- `hold_flag_i`  in  1  EX multi-cycle hold request.
- `bus_req_i`  in  1  EX load/store in progress.
- `bus_ack_i`  in  1  data bus completion.
- `irq_i`  in  1  external interrupt, level.
- `mret_i`  in  1  one-cycle pulse: EX retiring `mret`.
- `pc_wr_en_o`  out  1  load PC with `pc_wr_addr_o`.
- `pc_wr_addr_o`  out  32  redirect target.
- `hold_pc_o`  out  1  freeze PC.
- `hold_if_o`  out  1  freeze IF/ID register.
- `hold_id_o`  out  1  freeze ID/EX register.
- `flush_o`  out  1  load bubbles into IF/ID and ID/EX at next edge.
- `bus_err_o`  out  1  one-cycle pulse on bus timeout.
- `irq_ack_o`  out  1  one-cycle pulse on interrupt entry.
- `mepc_wr_o`  out  1  one-cycle write strobe for mepc.
- `mepc_o`  out  32  return address for the interrupt.

## Operation
- FSM states: RUN, BUS_WAIT, IRQ_ENTRY. Reset enters RUN.
- Other state: 32-bit `mepc_q`, `irq_active` flag, bus wait counter.
- RUN priority, highest first:
  - jump: `ex_valid_i & jump_en_i`. Drive `pc_wr_en_o`=1, `pc_wr_addr_o`=`jump_addr_i`, `flush_o`=1. No hold.
  - bus stall: `bus_req_i & !bus_ack_i`. Drive all three holds =1, go to BUS_WAIT, counter=1.
  - EX hold: `hold_flag_i`. Drive all three holds =1 while it is asserted. No state change.
  - interrupt accept: `irq_i & !irq_active & ex_valid_i`. Drive `hold_pc_o`=1, `flush_o`=1. Set `mepc_q` = `ex_ins_addr_i`+4 (mod 2^32); the EX instruction completes normally. Set `irq_active`. Go to IRQ_ENTRY.
- BUS_WAIT:
  - All holds =1 until release. Counter increments each cycle.
  - On `bus_ack_i`: holds =0 in that same cycle, return to RUN.
  - Counter reaches `BUS_TIMEOUT` without ack: `bus_err_o`=1 for one cycle, holds =0, return to RUN.
  - Ack and timeout in the same cycle: ack wins, no `bus_err_o`.
- IRQ_ENTRY, one cycle: `pc_wr_en_o`=1, `pc_wr_addr_o`=`IRQ_VEC`, `flush_o`=1, `irq_ack_o`=1, `mepc_wr_o`=1. Then return to RUN.
- `mret_i` clears `irq_active` in any state. If it coincides with an accept, the clear wins next cycle.
- `irq_i` held during the handler is ignored until `mret_i`.
- `mepc_o` = `mepc_q`, always.

## Timing
- Reset values: all outputs 0, `mepc_q`=0, `irq_active`=0, counter=0, state RUN.
- Jump redirect, holds and flush are combinational from the inputs and state: zero latency.
- Interrupt: accept cycle T, vector load at edge ending T+1. Latency 2 cycles from `irq_i` seen in RUN to the vector PC.
- A bus stall occupies 1 + N cycles for an ack arriving N cycles after entry. Timeout releases at cycle `BUS_TIMEOUT`.
- Reset asserted mid-BUS_WAIT or mid-IRQ_ENTRY returns to RUN at the next edge with no pulses emitted.

## Configuration
- `PIPE_CTRL_IRQ_EN` defined: interrupt logic as described above.
- Undefined:
  - `irq_i` and `mret_i` are ignored; IRQ_ENTRY is not built.
  - `irq_ack_o`, `mepc_wr_o` and `mepc_o` are tied to 0.
  - `mepc_q` and `irq_active` are removed.

## Structure
- Shared defines file `ctrl_defines.v` holds:
  - FSM state encodings (2-bit).
  - `IRQ_VEC` default.
  - the `PIPE_CTRL_IRQ_EN` switch.
- Sub-module `bus_wait_timer`: counter with clear, enable and terminal-count output, width `$clog2(BUS_TIMEOUT+1)`.

## Test plan
- Reset: `rst`=1 for 2 cycles with `irq_i`=1 → all outputs 0 during reset. First RUN cycle accepts the interrupt only if `ex_valid_i`=1.
- Jump: `jump_en_i`=1, `jump_addr_i`=0x80 → same cycle `pc_wr_en_o`=1, `pc_wr_addr_o`=0x80, `flush_o`=1, holds 0.
- Bus ack: `bus_req_i`=1, ack 3 cycles later → holds =1 for 3 cycles, 0 in the ack cycle, no `bus_err_o`.
- Bus timeout: `BUS_TIMEOUT`=16, ack never arrives → `bus_err_o` pulses once in the 16th stall cycle and holds release. Ack arriving in that cycle instead suppresses the pulse.
- Interrupt: `ex_ins_addr_i`=0x40, `irq_i`=1 → T: `flush_o`=1, `hold_pc_o`=1. T+1: PC←0x100, `irq_ack_o`=1, `mepc_o`=0x44. A second `irq_i` is ignored until `mret_i`.
- Collision: `jump_en_i` and `irq_i` in the same cycle → jump taken, interrupt accepted next eligible cycle with `mepc_o` = EX address + 4.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared types and defaults for the pipeline sequencing controller.
//            Holds the 2-bit FSM state encoding, the default interrupt vector,
//            the default bus timeout and a return-address helper.
//            The optional interrupt path is enabled by defining the macro
//            PIPE_CTRL_IRQ_EN; this package is identical in both builds.
// Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_BUS_WAIT  = 2'd1,
    ST_IRQ_ENTRY = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] IRQ_VEC_DEFAULT     = 32'h0000_0100;
  localparam int unsigned BUS_TIMEOUT_DEFAULT = 16;

  // Address of the instruction following the one in EX; wraps mod 2^32.
  function automatic logic [31:0] next_ins_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_wait_timer
// Purpose  : Bus wait-state counter with clear, enable and terminal count.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            clr_i         - return the count to zero (wins over en_i)
//            en_i          - increment the count
//            tc_o          - count is one below BUS_TIMEOUT, i.e. the next
//                            increment would reach the timeout
// Revision : 1.0  initial release
// ============================================================================
module bus_wait_timer #(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned       CNT_W  = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TC_VAL = CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count is 1 in the first BUS_WAIT cycle (second stall cycle), so
  // count == BUS_TIMEOUT-1 marks stall cycle number BUS_TIMEOUT.
  assign tc_o = (count_q == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Stall/flush/redirect controller for the 3-stage IF/ID/EX core.
//            Merges EX redirects and holds, data-bus wait states and
//            external interrupts. Interrupt logic is built only when the
//            macro PIPE_CTRL_IRQ_EN is defined; otherwise irq_i/mret_i are
//            ignored and irq_ack_o, mepc_wr_o, mepc_o are tied to 0.
// Ports    : ex_valid_i, ex_ins_addr_i  - EX occupancy and its address
//            jump_en_i, jump_addr_i     - EX redirect request
//            hold_flag_i                - EX multi-cycle hold
//            bus_req_i, bus_ack_i       - data bus handshake
//            irq_i, mret_i              - interrupt level, handler return
//            pc_wr_en_o, pc_wr_addr_o   - PC redirect
//            hold_pc_o/if_o/id_o        - stage freezes
//            flush_o                    - bubble IF/ID and ID/EX
//            bus_err_o                  - bus timeout pulse
//            irq_ack_o, mepc_wr_o, mepc_o - interrupt entry handshake
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC     = IRQ_VEC_DEFAULT,
  parameter int unsigned BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_ins_addr_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        bus_req_i,
  input  logic        bus_ack_i,
  input  logic        irq_i,
  input  logic        mret_i,
  output logic        pc_wr_en_o,
  output logic [31:0] pc_wr_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_o,
  output logic        hold_id_o,
  output logic        flush_o,
  output logic        bus_err_o,
  output logic        irq_ack_o,
  output logic        mepc_wr_o,
  output logic [31:0] mepc_o
);

  ctrl_state_e state_q, state_d;

  logic        pc_wr_en;
  logic [31:0] pc_wr_addr;
  logic        hold_all;
  logic        flush;
  logic        bus_err;
  logic        tmr_en;
  logic        tmr_clr;
  logic        tmr_tc;

`ifdef PIPE_CTRL_IRQ_EN
  logic        irq_accept;
  logic        hold_pc_only;
  logic        irq_ack;
  logic        mepc_wr;
  logic [31:0] mepc_q, mepc_d;
  logic        irq_active_q, irq_active_d;
`endif

  bus_wait_timer #(
    .BUS_TIMEOUT (BUS_TIMEOUT)
  ) u_bus_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    pc_wr_en   = 1'b0;
    pc_wr_addr = '0;
    hold_all   = 1'b0;
    flush      = 1'b0;
    bus_err    = 1'b0;
    tmr_en     = 1'b0;
    tmr_clr    = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
    irq_accept   = 1'b0;
    hold_pc_only = 1'b0;
    irq_ack      = 1'b0;
    mepc_wr      = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        if (ex_valid_i && jump_en_i) begin
          pc_wr_en   = 1'b1;
          pc_wr_addr = jump_addr_i;
          flush      = 1'b1;
        end else if (bus_req_i && !bus_ack_i) begin
          // The timer idles at zero in RUN; this increment makes it 1
          // in the first BUS_WAIT cycle.
          hold_all = 1'b1;
          tmr_en   = 1'b1;
          state_d  = ST_BUS_WAIT;
        end else if (hold_flag_i) begin
          hold_all = 1'b1;
`ifdef PIPE_CTRL_IRQ_EN
        end else if (irq_i && !irq_active_q && ex_valid_i) begin
          // EX retires normally; only the younger stages are discarded.
          irq_accept   = 1'b1;
          hold_pc_only = 1'b1;
          flush        = 1'b1;
          state_d      = ST_IRQ_ENTRY;
`endif
        end
      end
      ST_BUS_WAIT: begin
        // Ack is tested first so a same-cycle ack suppresses the error.
        if (bus_ack_i) begin
          tmr_clr = 1'b1;
          state_d = ST_RUN;
        end else if (tmr_tc) begin
          bus_err = 1'b1;
          tmr_clr = 1'b1;
          state_d = ST_RUN;
        end else begin
          hold_all = 1'b1;
          tmr_en   = 1'b1;
        end
      end
`ifdef PIPE_CTRL_IRQ_EN
      ST_IRQ_ENTRY: begin
        pc_wr_en   = 1'b1;
        pc_wr_addr = IRQ_VEC;
        flush      = 1'b1;
        irq_ack    = 1'b1;
        mepc_wr    = 1'b1;
        state_d    = ST_RUN;
      end
`endif
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low while reset is held, whatever the inputs do.
  assign pc_wr_en_o   = !rst && pc_wr_en;
  assign pc_wr_addr_o = rst ? 32'd0 : pc_wr_addr;
  assign hold_if_o    = !rst && hold_all;
  assign hold_id_o    = !rst && hold_all;
  assign flush_o      = !rst && flush;
  assign bus_err_o    = !rst && bus_err;

`ifdef PIPE_CTRL_IRQ_EN
  always_comb begin
    mepc_d       = irq_accept ? next_ins_addr(ex_ins_addr_i) : mepc_q;
    // A handler return in the accept cycle leaves the flag clear.
    irq_active_d = (irq_active_q || irq_accept) && !mret_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mepc_q       <= '0;
      irq_active_q <= 1'b0;
    end else begin
      mepc_q       <= mepc_d;
      irq_active_q <= irq_active_d;
    end
  end

  assign hold_pc_o = !rst && (hold_all || hold_pc_only);
  assign irq_ack_o = !rst && irq_ack;
  assign mepc_wr_o = !rst && mepc_wr;
  assign mepc_o    = mepc_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_i, mret_i, ex_ins_addr_i, IRQ_VEC};

  assign hold_pc_o = !rst && hold_all;
  assign irq_ack_o = 1'b0;
  assign mepc_wr_o = 1'b0;
  assign mepc_o    = '0;
`endif

endmodule
`default_nettype wire
